// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: MMIO register offsets,
// the spurious-acknowledge cause code and the service state encoding.
package int_pkg;

    localparam int N_IRQ_DEF = 8;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_CAUSE   = 2'd2;
    localparam logic [1:0] REG_SWINT   = 2'd3;

    localparam logic [4:0] CAUSE_NONE = 5'h1F;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } svc_state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt vector.
module int_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] elig,
    output logic         any,
    output logic [4:0]   idx
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        any = 1'b0;
        idx = 5'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                any = 1'b1;
                idx = 5'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Upstream interrupt controller: synchronises and edge-captures irq lines,
// masks them into a single Ireq and runs the Iack/eret service handshake.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | no interrupt in service, Ireq may be raised
//   ST_SERVICE | acknowledged interrupt in service, Ireq held off
module int_ctrl
    import int_pkg::*;
#(
    parameter int N_IRQ       = N_IRQ_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             ie,
    output logic             Ireq,
    input  logic             Iack,
    input  logic             eret,
    output logic [4:0]       int_cause,
    output logic             in_service,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] sync_d_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q;
    logic [4:0]       cause_q;
    logic             ireq_q, ireq_d;
    svc_state_t       state_q;

    logic [N_IRQ-1:0] edge_det, elig, win_oh;
    logic             any;
    logic [4:0]       idx;
    logic             wr_en, w1c, swint, mask_wr;
    logic             unused_wdata;

    assign unused_wdata = ^wdata[31:N_IRQ];

    assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_d_q;
    assign elig     = pending_q & mask_q;

    int_prio_enc #(.N(N_IRQ)) u_prio (
        .elig (elig),
        .any  (any),
        .idx  (idx)
    );

    assign wr_en   = sel & we;
    assign w1c     = wr_en && (addr == REG_PENDING);
    assign mask_wr = wr_en && (addr == REG_MASK);
    assign swint   = wr_en && (addr == REG_SWINT);

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            win_oh[i] = any && (idx == 5'(i));
        end
    end

    // Applied lowest priority first so a new set event always survives.
    always_comb begin
        pending_d = pending_q;
        if (w1c) begin
            pending_d = pending_d & ~wdata[N_IRQ-1:0];
        end
        if (Iack) begin
            pending_d = pending_d & ~win_oh;
        end
        pending_d = pending_d | edge_det;
        if (swint) begin
            pending_d = pending_d | wdata[N_IRQ-1:0];
        end
    end

    assign ireq_d = any & ie & (state_q == ST_IDLE) & ~Iack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_d_q  <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            ireq_q    <= 1'b0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_d_q  <= sync_q[SYNC_STAGES-1];
            pending_q <= pending_d;
            ireq_q    <= ireq_d;
            if (mask_wr) begin
                mask_q <= wdata[N_IRQ-1:0];
            end
        end
    end

    // Service FSM; Iack takes precedence over a coincident eret.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= 5'd0;
        end else begin
            if (Iack) begin
                state_q <= ST_SERVICE;
                cause_q <= any ? idx : CAUSE_NONE;
            end else if (eret) begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign Ireq       = ireq_q;
    assign int_cause  = cause_q;
    assign in_service = (state_q == ST_SERVICE);

    always_comb begin
        rdata = 32'd0;
        case (addr)
            REG_PENDING: rdata = 32'(pending_q);
            REG_MASK:    rdata = 32'(mask_q);
            REG_CAUSE:   rdata = {in_service, 26'd0, cause_q};
            default:     rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl with hand-computed expectations.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        ie;
    logic        Ireq;
    logic        Iack;
    logic        eret;
    logic [4:0]  int_cause;
    logic        in_service;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    int_ctrl #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .ie         (ie),
        .Ireq       (Ireq),
        .Iack       (Iack),
        .eret       (eret),
        .int_cause  (int_cause),
        .in_service (in_service),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic mmio_wr(input logic [1:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        sel   = 1'b0;
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic pulse_iack();
        Iack = 1'b1;
        tick();
        Iack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        irq_in = 8'h00;
        ie     = 1'b0;
        Iack   = 1'b0;
        eret   = 1'b0;
        sel    = 1'b0;
        we     = 1'b0;
        addr   = 2'd0;
        wdata  = 32'd0;
        ticks(2);
        reset = 1'b0;
        tick();

        chk("rst_ireq", 32'(Ireq), 32'd0);
        chk("rst_insvc", 32'(in_service), 32'd0);
        chk("rst_cause", 32'(int_cause), 32'd0);
        chk_rd("rst_pending", 2'd0, 32'd0);
        chk_rd("rst_mask", 2'd1, 32'd0);
        chk_rd("rst_causereg", 2'd2, 32'd0);

        // Test 1: single line, latency and handshake
        mmio_wr(2'd1, 32'h0000_0004);
        ie = 1'b1;
        irq_in[2] = 1'b1;
        ticks(3);
        chk("t1_ireq_early", 32'(Ireq), 32'd0);
        chk_rd("t1_pending", 2'd0, 32'h04);
        tick();
        chk("t1_ireq_rise", 32'(Ireq), 32'd1);
        irq_in[2] = 1'b0;
        pulse_iack();
        chk("t1_cause", 32'(int_cause), 32'd2);
        chk("t1_insvc", 32'(in_service), 32'd1);
        chk("t1_ireq_drop", 32'(Ireq), 32'd0);
        chk_rd("t1_pending_clr", 2'd0, 32'd0);
        pulse_eret();
        chk("t1_eret_insvc", 32'(in_service), 32'd0);
        chk("t1_eret_cause", 32'(int_cause), 32'd2);
        tick();
        chk("t1_ireq_idle", 32'(Ireq), 32'd0);

        // Test 2: simultaneous lines, priority and re-assertion after eret
        mmio_wr(2'd1, 32'h0000_00FF);
        irq_in[5] = 1'b1;
        irq_in[3] = 1'b1;
        ticks(4);
        chk("t2_ireq", 32'(Ireq), 32'd1);
        chk_rd("t2_pending", 2'd0, 32'h28);
        pulse_iack();
        chk("t2_cause_a", 32'(int_cause), 32'd3);
        chk_rd("t2_pending_a", 2'd0, 32'h20);
        tick();
        chk("t2_ireq_held", 32'(Ireq), 32'd0);
        pulse_eret();
        chk("t2_ireq_eret_edge", 32'(Ireq), 32'd0);
        tick();
        chk("t2_ireq_reassert", 32'(Ireq), 32'd1);
        pulse_iack();
        chk("t2_cause_b", 32'(int_cause), 32'd5);
        chk_rd("t2_pending_b", 2'd0, 32'h00);
        pulse_eret();
        irq_in = 8'h00;
        ticks(3);

        // Test 3: masked line stays pending, unmask raises Ireq
        mmio_wr(2'd1, 32'h0000_0000);
        irq_in[1] = 1'b1;
        ticks(3);
        irq_in[1] = 1'b0;
        chk_rd("t3_pending", 2'd0, 32'h02);
        ticks(2);
        chk("t3_ireq_masked", 32'(Ireq), 32'd0);
        mmio_wr(2'd1, 32'h0000_0002);
        tick();
        chk("t3_ireq_unmask", 32'(Ireq), 32'd1);
        pulse_iack();
        chk("t3_cause", 32'(int_cause), 32'd1);
        pulse_eret();

        // Test 4: set beats W1C on the same edge; SWINT sets pending
        mmio_wr(2'd1, 32'h0000_0000);
        irq_in[4] = 1'b1;
        ticks(2);
        mmio_wr(2'd0, 32'h0000_0010);
        chk_rd("t4_set_wins", 2'd0, 32'h10);
        mmio_wr(2'd0, 32'h0000_0010);
        chk_rd("t4_w1c", 2'd0, 32'h00);
        irq_in[4] = 1'b0;
        mmio_wr(2'd3, 32'h0000_0001);
        chk_rd("t4_swint", 2'd0, 32'h01);
        chk_rd("t4_swint_rd0", 2'd3, 32'h00);

        // Test 5: spurious Iack, then Iack and eret together
        pulse_iack();
        chk_rd("t5_spurious_cause", 2'd2, 32'h8000_001F);
        chk_rd("t5_pending_kept", 2'd0, 32'h01);
        pulse_eret();
        chk("t5_eret_insvc", 32'(in_service), 32'd0);
        Iack = 1'b1;
        eret = 1'b1;
        tick();
        Iack = 1'b0;
        eret = 1'b0;
        chk("t5_iack_wins", 32'(in_service), 32'd1);
        chk("t5_cause_none", 32'(int_cause), 32'h1F);

        // Test 6: reset mid-service discards everything
        pulse_eret();
        mmio_wr(2'd1, 32'h0000_00FF);
        mmio_wr(2'd3, 32'h0000_00FF);
        pulse_iack();
        chk("t6_cause_pre", 32'(int_cause), 32'd0);
        chk_rd("t6_pending_pre", 2'd0, 32'hFE);
        #2;
        reset = 1'b1;
        irq_in[6] = 1'b1;
        #1;
        chk("t6_rst_ireq", 32'(Ireq), 32'd0);
        chk("t6_rst_insvc", 32'(in_service), 32'd0);
        chk("t6_rst_cause", 32'(int_cause), 32'd0);
        chk_rd("t6_rst_pending", 2'd0, 32'd0);
        ticks(2);
        irq_in[6] = 1'b0;
        ticks(2);
        reset = 1'b0;
        mmio_wr(2'd1, 32'h0000_00FF);
        ticks(5);
        chk("t6_ireq_after", 32'(Ireq), 32'd0);
        chk_rd("t6_pending_after", 2'd0, 32'd0);
        irq_in[6] = 1'b1;
        ticks(4);
        chk("t6_new_edge", 32'(Ireq), 32'd1);
        pulse_iack();
        chk("t6_new_cause", 32'(int_cause), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
